// File: rtl/np_mem_responder.sv
// rtl/np_mem_responder.sv - memory-side responder for the np core: imem/dmem, byte boot loader, run/halt control
// Loads imem from a little-endian byte stream, then releases the core and counts run cycles until halt.
module np_mem_responder #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int MEMSIZE  = 1 << ADDRSIZE,
  parameter int CYCW     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_start,
  input  logic [ADDRSIZE:0]   ld_len,
  input  logic [7:0]          ld_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  output logic                cpu_reset,
  input  logic [ADDRSIZE-1:0] cpu_in_address,
  input  logic                cpu_in_wr,
  input  logic [WIDTH-1:0]    cpu_in_dataOut,
  output logic [WIDTH-1:0]    cpu_in_dataIn,
  input  logic [ADDRSIZE-1:0] cpu_address,
  input  logic                cpu_wr,
  input  logic [WIDTH-1:0]    cpu_dataOut,
  output logic [WIDTH-1:0]    cpu_dataIn,
  input  logic                cpu_halt,
  input  logic [ADDRSIZE-1:0] dbg_addr,
  output logic [WIDTH-1:0]    dbg_data,
  output logic                running,
  output logic                done,
  output logic [CYCW-1:0]     run_cycles
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_t;

  localparam logic [ADDRSIZE:0] MEM_WORDS = (ADDRSIZE+1)'(MEMSIZE);

  state_t            state;
  logic [1:0]        byte_idx;
  logic [ADDRSIZE:0] load_addr;
  logic [ADDRSIZE:0] load_len;
  logic [WIDTH-1:0]  word_acc;

  logic [WIDTH-1:0] imem [MEMSIZE];
  logic [WIDTH-1:0] dmem [MEMSIZE];

  logic             byte_fire;
  logic             word_done;
  logic             last_word;
  logic [WIDTH-1:0] word_next;

  // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0].
  assign word_next = {ld_data, word_acc[WIDTH-1:8]};
  assign byte_fire = (state == LOAD) && ld_valid && ld_ready;
  assign word_done = byte_fire && (byte_idx == 2'd3);
  assign last_word = word_done && ((load_addr + 1'b1) == load_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ld_ready   <= 1'b0;
      cpu_reset  <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      run_cycles <= '0;
      byte_idx   <= 2'd0;
      load_addr  <= '0;
      load_len   <= '0;
      word_acc   <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (ld_start) begin
            run_cycles <= '0;
            done       <= 1'b0;
            if (ld_len != '0) begin
              state     <= LOAD;
              ld_ready  <= 1'b1;
              load_addr <= '0;
              byte_idx  <= 2'd0;
              word_acc  <= '0;
              load_len  <= (ld_len > MEM_WORDS) ? MEM_WORDS : ld_len;
            end else begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              running   <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (byte_fire) begin
            byte_idx <= byte_idx + 2'd1;
            word_acc <= word_next;
            if (word_done) load_addr <= load_addr + 1'b1;
            if (last_word) begin
              state     <= RUN;
              ld_ready  <= 1'b0;
              cpu_reset <= 1'b0;
              running   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
          if (cpu_halt) begin
            state     <= HALTED;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Loader and core writes are exclusive by state; reset blocks both so a reset edge never lands a word.
  always_ff @(posedge clk) begin
    if (!reset && word_done)
      imem[load_addr[ADDRSIZE-1:0]] <= word_next;
    else if (!reset && (state == RUN) && cpu_in_wr)
      imem[cpu_in_address] <= cpu_in_dataOut;
  end

  assign cpu_in_dataIn = imem[cpu_in_address];

  always_ff @(posedge clk) begin
    cpu_dataIn <= dmem[cpu_address];
    if (!reset && (state == RUN) && cpu_wr)
      dmem[cpu_address] <= cpu_dataOut;
  end

  always_ff @(posedge clk) begin
    if (reset) dbg_data <= '0;
    else       dbg_data <= dmem[dbg_addr];
  end

endmodule

// File: tb/tb_np_mem_responder.sv
// tb/tb_np_mem_responder.sv - directed scoreboard bench for np_mem_responder
// Expected imem words are queued as bytes are driven and checked through the instruction port.
module tb_np_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_start = 1'b0;
  logic [12:0] ld_len = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        cpu_reset;
  logic [11:0] cpu_in_address = '0;
  logic        cpu_in_wr = 1'b0;
  logic [31:0] cpu_in_dataOut = '0;
  logic [31:0] cpu_in_dataIn;
  logic [11:0] cpu_address = '0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_dataOut = '0;
  logic [31:0] cpu_dataIn;
  logic        cpu_halt = 1'b0;
  logic [11:0] dbg_addr = '0;
  logic [31:0] dbg_data;
  logic        running;
  logic        done;
  logic [31:0] run_cycles;

  np_mem_responder dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .ld_len(ld_len), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .cpu_reset(cpu_reset),
    .cpu_in_address(cpu_in_address), .cpu_in_wr(cpu_in_wr), .cpu_in_dataOut(cpu_in_dataOut),
    .cpu_in_dataIn(cpu_in_dataIn),
    .cpu_address(cpu_address), .cpu_wr(cpu_wr), .cpu_dataOut(cpu_dataOut), .cpu_dataIn(cpu_dataIn),
    .cpu_halt(cpu_halt), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .running(running), .done(done), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cycles = 0;
  bit   in_run_model = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the model counts every edge the DUT should spend in RUN.
  task automatic step();
    @(posedge clk);
    if (in_run_model) exp_cycles++;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gapped, input bit last);
    ld_data  = b;
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    if (gapped && !last) begin
      step();
      chk("ld_ready_in_gap", ld_ready, 1'b1);
    end
  endtask

  task automatic send_word(input logic [11:0] addr, input logic [31:0] w, input bit gapped, input bit last);
    sb.push_back('{addr: addr, data: w});
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], gapped, last && (i == 3));
  endtask

  task automatic check_sb(input string tag);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cpu_in_address = e.addr;
      #1;
      chk(tag, cpu_in_dataIn, e.data);
    end
  endtask

  task automatic start(input logic [12:0] len);
    ld_len   = len;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic halt_core();
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    in_run_model = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_dbg_data", dbg_data, 32'd0);
    reset = 1'b0;
    step();

    // Two-word streaming load
    start(13'd2);
    chk("load_ld_ready", ld_ready, 1'b1);
    chk("load_cpu_reset", cpu_reset, 1'b1);
    send_word(12'd0, 32'h0000_0001, 1'b0, 1'b0);
    send_word(12'd1, 32'h1234_5678, 1'b0, 1'b1);
    in_run_model = 1'b1;
    chk("ld_ready_after_last", ld_ready, 1'b0);
    chk("run_cpu_reset", cpu_reset, 1'b0);
    chk("run_running", running, 1'b1);
    check_sb("imem_load2");

    // Data port: zero write then real write, then read back
    cpu_address = 12'd5; cpu_wr = 1'b1; cpu_dataOut = 32'h0;
    step();
    cpu_dataOut = 32'h0000_002A;
    step();
    chk("dmem_read_before_write", cpu_dataIn, 32'h0);
    cpu_wr = 1'b0;
    step();
    chk("dmem_read", cpu_dataIn, 32'h0000_002A);
    dbg_addr = 12'd5;
    step();
    chk("dbg_read", dbg_data, 32'h0000_002A);

    // Instruction-port write while running
    cpu_in_address = 12'd10; cpu_in_wr = 1'b1; cpu_in_dataOut = 32'hCAFE_F00D;
    step();
    cpu_in_wr = 1'b0;
    sb.push_back('{addr: 12'd10, data: 32'hCAFE_F00D});
    check_sb("imem_cpu_write");

    halt_core();
    chk("halt_done", done, 1'b1);
    chk("halt_cpu_reset", cpu_reset, 1'b1);
    chk("halt_run_cycles", run_cycles, 32'(exp_cycles));
    step();
    chk("halt_cycles_frozen", run_cycles, 32'(exp_cycles));

    // Writes while halted are dropped
    cpu_address = 12'd5; cpu_wr = 1'b1; cpu_dataOut = 32'hDEAD_BEEF;
    step();
    cpu_wr = 1'b0;
    step();
    step();
    chk("halted_write_ignored", dbg_data, 32'h0000_002A);

    // Gapped single-word load from HALTED
    start(13'd1);
    chk("gap_start_ready", ld_ready, 1'b1);
    chk("gap_done_cleared", done, 1'b0);
    send_word(12'd0, 32'hDDCC_BBAA, 1'b1, 1'b1);
    in_run_model = 1'b1;
    chk("gap_running", running, 1'b1);
    chk("gap_ld_ready_low", ld_ready, 1'b0);
    sb.push_back('{addr: 12'd1, data: 32'h1234_5678});
    check_sb("imem_gapped");
    halt_core();

    // Zero-length start reuses imem and restarts the counter
    start(13'd0);
    in_run_model = 1'b1;
    exp_cycles = 0;
    chk("len0_running", running, 1'b1);
    chk("len0_cpu_reset", cpu_reset, 1'b0);
    chk("len0_run_cycles", run_cycles, 32'd0);
    sb.push_back('{addr: 12'd0, data: 32'hDDCC_BBAA});
    check_sb("imem_kept");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        ld_len = 13'd1;
        ld_start = 1'b1;
      end
      step();
      if (i == 3) begin
        ld_start = 1'b0;
        chk("start_ignored_running", running, 1'b1);
        chk("start_ignored_ready", ld_ready, 1'b0);
      end
    end
    halt_core();
    chk("halt_after_10", run_cycles, 32'd11);
    chk("halt_after_10_done", done, 1'b1);

    // Reset in the middle of the second word of a two-word load
    start(13'd2);
    send_word(12'd0, 32'h4433_2211, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("midload_ld_ready", ld_ready, 1'b0);
    chk("midload_cpu_reset", cpu_reset, 1'b1);
    chk("midload_running", running, 1'b0);
    chk("midload_done", done, 1'b0);
    sb.push_back('{addr: 12'd1, data: 32'h1234_5678});
    check_sb("imem_midload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
